// File: rtl/weight_stream_buffer_if.sv
`default_nettype none
// ============================================================================
// weight_stream_buffer_if : memory read channel + network weight port bundle
// Rev 1.0
// ============================================================================
interface weight_stream_buffer_if;
    logic         start;
    logic [31:0]  base_addr;
    logic [15:0]  num_lines;
    logic         read_request_valid;
    logic [31:0]  address;
    logic         buffer_addr_valid;
    logic         data_valid;
    logic [511:0] read_data;
    logic         req_weight;
    logic         done_weight;
    logic [63:0]  weights [7:0];
    logic         weights_vld;
    logic         busy;
    logic         done;

    modport master (
        output start, base_addr, num_lines, buffer_addr_valid, data_valid,
               read_data, req_weight, done_weight,
        input  read_request_valid, address, weights, weights_vld, busy, done
    );

    modport slave (
        input  start, base_addr, num_lines, buffer_addr_valid, data_valid,
               read_data, req_weight, done_weight,
        output read_request_valid, address, weights, weights_vld, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/weight_stream_buffer.sv
`default_nettype none
// ============================================================================
// weight_stream_buffer : in-order 512-bit line fetcher feeding a network's
//                        8x64-bit weight port through a DEPTH-line FIFO
// Rev 1.0
// ============================================================================
module weight_stream_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_BYTES = 64
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    weight_stream_buffer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        DONE_P = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [15:0]   req_left, req_left_n;
    logic [15:0]   outstanding, outstanding_n;
    logic [15:0]   count, count_n;
    logic [31:0]   addr, addr_n;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [511:0]  mem [DEPTH];

    logic req_ok, accept, ret, flush, push, pop;

    // Requests are throttled so every accepted line already owns a FIFO slot.
    assign req_ok = (state == RUN) && (req_left != 16'd0) &&
                    (({1'b0, outstanding} + {1'b0, count}) < 17'(DEPTH));
    assign accept = req_ok && bus.buffer_addr_valid;
    assign ret    = bus.data_valid && (outstanding != 16'd0);
    assign flush  = (state == RUN) && bus.done_weight;
    assign push   = (state == RUN) && ret && !flush;
    assign pop    = bus.req_weight && bus.weights_vld && !flush;

    assign bus.read_request_valid = req_ok;
    assign bus.address            = addr;
    assign bus.weights_vld        = (state == RUN) && (count != 16'd0);
    assign bus.busy               = (state != IDLE);
    assign bus.done               = (state == DONE_P);

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign bus.weights[i] = mem[rd_ptr][64*i +: 64];
    end

    always_comb begin
        state_n       = state;
        req_left_n    = req_left;
        addr_n        = addr;
        outstanding_n = outstanding + 16'(accept) - 16'(ret);
        count_n       = count + 16'(push) - 16'(pop);
        if (accept) begin
            addr_n     = addr + 32'(LINE_BYTES);
            req_left_n = req_left - 16'd1;
        end
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_lines == 16'd0) begin
                        state_n = DONE_P;
                    end else begin
                        state_n    = RUN;
                        addr_n     = bus.base_addr;
                        req_left_n = bus.num_lines;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_n    = FLUSH;
                    req_left_n = 16'd0;
                    count_n    = 16'd0;
                end else if (req_left_n == 16'd0 && outstanding_n == 16'd0 &&
                             count_n == 16'd0) begin
                    state_n = DONE_P;
                end
            end
            FLUSH: begin
                if (outstanding_n == 16'd0) begin
                    state_n = DONE_P;
                end
            end
            DONE_P:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_left    <= '0;
            outstanding <= '0;
            count       <= '0;
            addr        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= state_n;
            req_left    <= req_left_n;
            outstanding <= outstanding_n;
            count       <= count_n;
            addr        <= addr_n;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Line storage carries no reset; contents only matter while weights_vld=1.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.read_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_weight_stream_buffer.sv
`default_nettype none
// ============================================================================
// tb_weight_stream_buffer : directed bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_weight_stream_buffer;
    localparam int DEPTH      = 4;
    localparam int LINE_BYTES = 64;
    localparam int LAT        = 2;

    typedef enum int {M_IDLE, M_RUN, M_FLUSH, M_DONE} mode_t;

    logic clk;
    logic rst_n;

    weight_stream_buffer_if wif ();

    weight_stream_buffer #(.DEPTH(DEPTH), .LINE_BYTES(LINE_BYTES)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (wif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks;
    int           n_errors;
    int           cyc;
    mode_t        m_mode;
    int           m_req_left;
    int           m_out;
    logic [31:0]  m_addr;
    logic [511:0] m_fifo [$];
    logic [31:0]  acc_addrs [$];
    logic [63:0]  pop_words [$];
    int           resp_due [$];
    logic [31:0]  resp_addr [$];
    int           done_cnt, done_cyc, last_pop_cyc, disc_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [511:0] line_of(input logic [31:0] a);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[64*i +: 64] = {a + 32'(i), 32'hD00D_0000 + 32'(i)};
        return l;
    endfunction

    // Reference: compare current DUT outputs, then advance the model by one edge.
    task automatic step_model();
        logic         m_rrv, m_wvld, acc, ret;
        logic [511:0] head;
        m_rrv  = (m_mode == M_RUN) && (m_req_left != 0) && ((m_out + m_fifo.size()) < DEPTH);
        m_wvld = (m_mode == M_RUN) && (m_fifo.size() != 0);
        if (!rst_n) begin
            m_mode = M_IDLE; m_req_left = 0; m_out = 0; m_addr = '0; m_fifo.delete();
            chk("reset_rrv",   64'(wif.read_request_valid), 64'd0);
            chk("reset_addr",  64'(wif.address),            64'd0);
            chk("reset_wvld",  64'(wif.weights_vld),        64'd0);
            chk("reset_busy",  64'(wif.busy),               64'd0);
            chk("reset_done",  64'(wif.done),               64'd0);
        end else begin
            chk("read_request_valid", 64'(wif.read_request_valid), 64'(m_rrv));
            chk("address",            64'(wif.address),            64'(m_addr));
            chk("weights_vld",        64'(wif.weights_vld),        64'(m_wvld));
            chk("busy",               64'(wif.busy),               64'(m_mode != M_IDLE));
            chk("done",               64'(wif.done),               64'(m_mode == M_DONE));
            if (m_wvld) begin
                head = m_fifo[0];
                for (int i = 0; i < 8; i++) chk("weights", wif.weights[i], head[64*i +: 64]);
            end
            if (wif.read_request_valid && wif.buffer_addr_valid) begin
                acc_addrs.push_back(wif.address);
                resp_due.push_back(cyc + LAT);
                resp_addr.push_back(wif.address);
            end
            if (wif.done) begin done_cnt++; done_cyc = cyc; end
            acc = m_rrv && wif.buffer_addr_valid;
            ret = wif.data_valid && (m_out != 0);
            case (m_mode)
                M_IDLE: if (wif.start) begin
                    if (wif.num_lines == 16'd0) m_mode = M_DONE;
                    else begin
                        m_mode = M_RUN; m_addr = wif.base_addr; m_req_left = int'(wif.num_lines);
                    end
                end
                M_RUN: begin
                    if (acc) begin m_addr = m_addr + 32'(LINE_BYTES); m_req_left--; end
                    m_out = m_out + int'(acc) - int'(ret);
                    if (wif.done_weight) begin
                        m_fifo.delete(); m_req_left = 0; m_mode = M_FLUSH;
                    end else begin
                        if (m_wvld && wif.req_weight) begin
                            head = m_fifo.pop_front();
                            pop_words.push_back(head[63:0]);
                            last_pop_cyc = cyc;
                        end
                        if (ret) m_fifo.push_back(wif.read_data);
                        if (m_req_left == 0 && m_out == 0 && m_fifo.size() == 0) m_mode = M_DONE;
                    end
                end
                M_FLUSH: begin
                    if (ret) begin m_out--; disc_cnt++; end
                    if (m_out == 0) m_mode = M_DONE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
        cyc++;
    endtask

    // One clock: check at negedge, then after the edge drive the memory's return.
    task automatic tick();
        @(negedge clk);
        step_model();
        @(posedge clk);
        #1;
        if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
            wif.data_valid = 1'b1;
            wif.read_data  = line_of(resp_addr[0]);
            void'(resp_due.pop_front());
            void'(resp_addr.pop_front());
        end else begin
            wif.data_valid = 1'b0;
        end
    endtask

    task automatic start_stream(input logic [31:0] base, input logic [15:0] n);
        wif.base_addr = base; wif.num_lines = n; wif.start = 1'b1;
        tick();
        wif.start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < maxc) begin tick(); k++; end
        chk("done_seen", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic clear_logs();
        acc_addrs.delete(); pop_words.delete(); disc_cnt = 0;
    endtask

    task automatic check_order(input logic [31:0] base, input int n);
        logic [511:0] l;
        chk("pop_count", 64'(pop_words.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            l = line_of(base + 32'(LINE_BYTES * k));
            if (k < pop_words.size()) chk("pop_order", pop_words[k], l[63:0]);
        end
    endtask

    initial begin
        int k;
        n_checks = 0; n_errors = 0; cyc = 0; m_mode = M_IDLE;
        m_req_left = 0; m_out = 0; m_addr = '0;
        done_cnt = 0; done_cyc = 0; last_pop_cyc = 0; disc_cnt = 0;
        rst_n = 1'b0;
        wif.start = 1'b0; wif.base_addr = '0; wif.num_lines = '0;
        wif.buffer_addr_valid = 1'b0; wif.data_valid = 1'b0; wif.read_data = '0;
        wif.req_weight = 1'b0; wif.done_weight = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic 3-line stream
        clear_logs();
        wif.buffer_addr_valid = 1'b1; wif.req_weight = 1'b1;
        start_stream(32'h0000_1000, 16'd3);
        wait_done(60);
        chk("t2_accepts", 64'(acc_addrs.size()), 64'd3);
        if (acc_addrs.size() == 3) begin
            chk("t2_addr0", 64'(acc_addrs[0]), 64'h1000);
            chk("t2_addr1", 64'(acc_addrs[1]), 64'h1040);
            chk("t2_addr2", 64'(acc_addrs[2]), 64'h1080);
        end
        check_order(32'h0000_1000, 3);
        chk("t2_done_latency", 64'(done_cyc), 64'(last_pop_cyc + 1));
        tick();

        // FIFO back-pressure: only DEPTH lines requested while nobody consumes
        clear_logs();
        wif.req_weight = 1'b0;
        start_stream(32'h0000_8000, 16'd10);
        repeat (20) tick();
        chk("t3_accepts_full", 64'(acc_addrs.size()), 64'd4);
        chk("t3_rrv_low",      64'(wif.read_request_valid), 64'd0);
        wif.req_weight = 1'b1;
        wait_done(200);
        chk("t3_accepts_total", 64'(acc_addrs.size()), 64'd10);
        check_order(32'h0000_8000, 10);
        tick();

        // Request held stable under memory back-pressure
        clear_logs();
        wif.buffer_addr_valid = 1'b0;
        start_stream(32'h0000_2000, 16'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_rrv",  64'(wif.read_request_valid), 64'd1);
            chk("t4_hold_addr", 64'(wif.address), 64'h2000);
            tick();
        end
        wif.buffer_addr_valid = 1'b1;
        tick();
        wif.buffer_addr_valid = 1'b0;
        chk("t4_next_addr", 64'(wif.address), 64'h2040);
        chk("t4_accepts",   64'(acc_addrs.size()), 64'd1);
        wait_done(60);
        tick();

        // Abort mid-stream
        clear_logs();
        wif.buffer_addr_valid = 1'b1; wif.req_weight = 1'b1;
        start_stream(32'h0000_6000, 16'd8);
        k = 0;
        while (!(pop_words.size() >= 2 && m_out == 2) && k < 60) begin tick(); k++; end
        chk("t5_setup", 64'(pop_words.size() >= 2 && m_out == 2), 64'd1);
        wif.done_weight = 1'b1;
        tick();
        wif.done_weight = 1'b0;
        k = acc_addrs.size();
        wait_done(60);
        chk("t5_no_new_requests", 64'(acc_addrs.size()), 64'(k));
        chk("t5_discarded",       64'(disc_cnt), 64'd2);
        tick();

        // Address wrap, empty stream, start while busy
        clear_logs();
        start_stream(32'hFFFF_FFC0, 16'd2);
        wait_done(60);
        chk("t6_accepts", 64'(acc_addrs.size()), 64'd2);
        if (acc_addrs.size() == 2) chk("t6_wrap_addr", 64'(acc_addrs[1]), 64'h0);
        tick();
        clear_logs();
        start_stream(32'h0000_7000, 16'd0);
        chk("t6_zero_done", 64'(wif.done), 64'd1);
        tick();
        chk("t6_zero_done_pulse", 64'(wif.done), 64'd0);
        chk("t6_zero_idle",       64'(wif.busy), 64'd0);
        chk("t6_zero_no_req",     64'(acc_addrs.size()), 64'd0);
        start_stream(32'h0000_3000, 16'd3);
        start_stream(32'h0000_5000, 16'd9);
        wait_done(80);
        chk("t6_busy_start_accepts", 64'(acc_addrs.size()), 64'd3);
        check_order(32'h0000_3000, 3);
        tick();

        // Asynchronous reset with two lines in flight
        clear_logs();
        wif.req_weight = 1'b0;
        start_stream(32'h0000_4000, 16'd8);
        k = 0;
        while (m_out != 2 && k < 20) begin tick(); k++; end
        chk("t1_setup", 64'(m_out), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t1_rrv",  64'(wif.read_request_valid), 64'd0);
        chk("t1_addr", 64'(wif.address),            64'd0);
        chk("t1_wvld", 64'(wif.weights_vld),        64'd0);
        chk("t1_busy", 64'(wif.busy),               64'd0);
        chk("t1_done", 64'(wif.done),               64'd0);
        tick();
        rst_n = 1'b1;
        wif.req_weight = 1'b1;
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_after_wvld", 64'(wif.weights_vld), 64'd0);
        end
        chk("t1_nothing_popped", 64'(pop_words.size()), 64'd0);
        chk("t1_returns_drained", 64'(resp_due.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
